// File: rtl/intc_pkg.sv
// intc_pkg: shared constants, source indices and FSM states for the interrupt controller
package intc_pkg;
    localparam logic [15:0] INTC_IF_ADDR  = 16'hFF0F;
    localparam logic [15:0] INTC_IE_ADDR  = 16'hFFFF;
    localparam logic [15:0] INTC_VEC_BASE = 16'h0040;
    localparam int SRC_VBLANK = 0;
    localparam int SRC_LCD    = 1;
    localparam int SRC_TIMER  = 2;
    localparam int SRC_SERIAL = 3;
    localparam int SRC_JOYPAD = 4;
    typedef enum logic [1:0] {IDLE, REQ, DISP} state_t;
endpackage

// File: rtl/interrupt_ctrl_if.sv
// interrupt_ctrl_if: memory-mapped peripheral bus shared by the IF/IE registers
interface interrupt_ctrl_if;
    logic [15:0] address;
    logic [7:0]  indata;
    logic [7:0]  outdata;
    logic        load;
    logic        store;
    modport master (output address, indata, load, store, input outdata);
    modport slave  (input address, indata, load, store, output outdata);
endinterface

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: lowest-set-bit encoder, vblank has highest priority
module intc_prio_enc
    import intc_pkg::*;
(
    input  logic [4:0] req,
    output logic [2:0] idx,
    output logic       valid
);
    always_comb begin
        idx = req[SRC_VBLANK] ? 3'(SRC_VBLANK) :
              req[SRC_LCD]    ? 3'(SRC_LCD)    :
              req[SRC_TIMER]  ? 3'(SRC_TIMER)  :
              req[SRC_SERIAL] ? 3'(SRC_SERIAL) : 3'(SRC_JOYPAD);
        valid = |req;
    end
endmodule

// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: Game Boy IF/IE interrupt controller; INTC_DELAYED_EI_EN delays EI by one instruction
module interrupt_ctrl
    import intc_pkg::*;
#(
    parameter logic [15:0] IF_ADDR  = INTC_IF_ADDR,
    parameter logic [15:0] IE_ADDR  = INTC_IE_ADDR,
    parameter logic [15:0] VEC_BASE = INTC_VEC_BASE
) (
    input  logic                   clockgb,
    input  logic                   resetn,
    interrupt_ctrl_if.slave        bus,
    input  logic [4:0]             src_int,
    input  logic                   ei,
    input  logic                   di,
    input  logic                   reti,
    input  logic                   insn_boundary,
    output logic                   int_req,
    input  logic                   int_ack,
    output logic [15:0]            int_vector,
    output logic                   wake
);
    state_t state, state_n;
    logic [4:0] if_q, if_n, pending;
    logic [7:0] ie_q;
    logic ime, ime_n, ei_pend, ei_pend_n, ei_seen, ei_seen_n;
    logic [15:0] vec_n;
    logic [2:0] idx;
    logic valid, ack, wr_if, wr_ie;

    assign pending = if_q & ie_q[4:0];
    assign wr_if = bus.store && bus.address == IF_ADDR;
    assign wr_ie = bus.store && bus.address == IE_ADDR;
    assign ack = state == REQ && int_ack;
    assign int_req = state == REQ;
    assign bus.outdata = !bus.load ? 8'h00 :
                         bus.address == IF_ADDR ? {3'b111, if_q} :
                         bus.address == IE_ADDR ? ie_q : 8'h00;

    intc_prio_enc u_enc (.req(pending), .idx(idx), .valid(valid));

    always_comb begin
        state_n = state;
        if_n = if_q;
        ime_n = ime;
        vec_n = int_vector;
        ei_pend_n = ei_pend;
        ei_seen_n = ei_seen;
        case (state)
            IDLE: state_n = ime && |pending ? REQ : IDLE;
            REQ: begin
                if (ack) begin
                    // priority is re-resolved at ack so late IE/IF writes pick the vector
                    state_n = DISP;
                    vec_n = valid ? VEC_BASE + {10'd0, idx, 3'd0} : 16'h0000;
                    ime_n = 1'b0;
                    if (valid) if_n[idx] = 1'b0;
                end else if (!ime) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (wr_if) if_n = bus.indata[4:0];
        if_n = if_n | src_int;
        if (reti) ime_n = 1'b1;
`ifdef INTC_DELAYED_EI_EN
        // first boundary is the instruction after EI starting, second is it completing
        if (ei) begin
            ei_pend_n = 1'b1;
            ei_seen_n = 1'b0;
        end else if (ei_pend && insn_boundary) begin
            ei_seen_n = !ei_seen;
            ei_pend_n = !ei_seen;
            if (ei_seen) ime_n = 1'b1;
        end
`else
        if (ei) ime_n = 1'b1;
        ei_pend_n = 1'b0;
        ei_seen_n = 1'b0;
`endif
        if (di) begin
            ime_n = 1'b0;
            ei_pend_n = 1'b0;
            ei_seen_n = 1'b0;
        end
    end

`ifndef INTC_DELAYED_EI_EN
    logic unused;
    assign unused = ^{insn_boundary, ei_pend, ei_seen};
`endif

    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            if_q <= '0;
            ie_q <= '0;
            ime <= 1'b0;
            ei_pend <= 1'b0;
            ei_seen <= 1'b0;
            int_vector <= '0;
            wake <= 1'b0;
        end else begin
            state <= state_n;
            if_q <= if_n;
            ie_q <= wr_ie ? bus.indata : ie_q;
            ime <= ime_n;
            ei_pend <= ei_pend_n;
            ei_seen <= ei_seen_n;
            int_vector <= vec_n;
            wake <= |pending;
        end
    end
endmodule
